vertex_mem_responder: RTL and testbench
=======================================

VERTEX_MEM_RESPONDER -- requirements
Module: vertex_mem_responder

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning address and data width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, meaning write-buffer entries; power of two, >= 2.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port rdEn  input  1  read request from the matrix processor.
REQ-006 SHALL have port rdAddr  input  WIDTH  read word address.
REQ-007 SHALL have port rdData  output  WIDTH  read response data, valid when rdValid=1.
REQ-008 SHALL have port rdValid  output  1  read response strobe.
REQ-009 SHALL have port wrEn  input  1  write request.
REQ-010 SHALL have port wrAddr  input  WIDTH  write word address.
REQ-011 SHALL have port wrData  input  WIDTH  write data.
REQ-012 SHALL have port stall  output  1  combinational; requester holds rdEn/wrEn and their address/data stable while high.
REQ-013 SHALL have port idle  output  1  write buffer empty and no read response pending.
REQ-014 SHALL have port memAddr  output  WIDTH  single-port SRAM address.
REQ-015 SHALL have port memWData  output  WIDTH  SRAM write data.
REQ-016 SHALL have port memWe  output  1  SRAM write enable.
REQ-017 SHALL have port memRData  input  WIDTH  SRAM read data, 1-cycle latency after address.

Function
REQ-018 SHALL hold a FIFO write buffer of DEPTH {addr,data} entries with an occupancy counter, count range 0..DEPTH.
REQ-019 SHALL compute hit = rdEn AND any valid buffer entry whose address equals rdAddr.
REQ-020 SHALL drive stall = hit OR (count == DEPTH AND wrEn).
REQ-021 SHALL accept a read when rdEn=1 and stall=0, and accept a write when wrEn=1 and stall=0; read and write may both be accepted in one cycle.
REQ-022 SHALL, on an accepted read in cycle N, drive memAddr=rdAddr, memWe=0 in cycle N, and assert rdValid=1 in cycle N+1 with rdData=memRData.
REQ-023 SHALL hold rdValid=0 in every cycle not following an accepted read; rdData is don't-care when rdValid=0.
REQ-024 SHALL enqueue an accepted write at the tail; a write is never issued to SRAM in its acceptance cycle.
REQ-025 SHALL, in any cycle with no accepted read and count > 0 (including stall cycles), drain the head entry: memAddr=head addr, memWData=head data, memWe=1, count decrements.
REQ-026 SHALL give read priority over draining; drain is deferred while reads are accepted.
REQ-027 SHALL allow enqueue and drain in the same cycle, leaving count unchanged.
REQ-028 SHALL, when read and write to the same address are accepted in the same cycle, return the pre-write memory value (read ordered before write).
REQ-029 SHALL, on a hit, keep stalling and draining until no buffer entry matches rdAddr, then accept the read, so reads never observe stale data.
REQ-030 SHALL, when count == DEPTH and wrEn=1, stall until one entry drains; no write is dropped or overwritten.
REQ-031 SHALL wrap FIFO head/tail pointers modulo DEPTH.
REQ-032 SHALL drive memWe=0, memAddr=0, memWData=0 when neither reading nor draining.
REQ-033 SHALL drive idle = (count == 0) AND NOT rdValid-pending.

Reset
REQ-034 SHALL, with rst=1 at a clock edge, clear count, head and tail pointers, and the pending-read flag, discarding buffered writes.
REQ-035 SHALL during and after reset drive rdValid=0, memWe=0, stall=0 (given rdEn=wrEn=0), idle=1.
REQ-036 SHALL, with reset asserted mid-drain, issue no further SRAM writes from the discarded entries.

Verification
REQ-037 Read: rdEn=1, rdAddr=0x10, SRAM holds 0xCAFE -> memAddr=0x10, memWe=0 same cycle; rdValid=1, rdData=0xCAFE next cycle.
REQ-038 Buffered write: wrEn=1, wrAddr=0x20, wrData=0x55, no reads -> next cycle memWe=1, memAddr=0x20, memWData=0x55; idle=1 after.
REQ-039 Full: 5 writes on consecutive cycles with rdEn=1 held (no hit) -> stall=1 on 5th write; rdEn dropped -> drains in order, 5th accepted, all 5 reach SRAM in issue order.
REQ-040 Hazard: write 0x30<=0x77 buffered, then rdEn rdAddr=0x30 -> stall=1 until drained, then rdValid returns 0x77.
REQ-041 Same-cycle: read and write both to 0x40 (old 0x1), new data 0x2 -> rdData=0x1; later read of 0x40 returns 0x2.
REQ-042 Reset mid-operation: 3 writes buffered, rst=1 one cycle -> no further memWe, idle=1, count=0.

Source files
------------

// File: rtl/vertex_mem_responder.sv
// Read/write front end for a single-port vertex SRAM. Writes are posted into a FIFO
// and drained in idle read slots; reads that hit a buffered address wait for it to drain.
module vertex_mem_responder #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rdEn,
  input  logic [WIDTH-1:0] rdAddr,
  output logic [WIDTH-1:0] rdData,
  output logic             rdValid,
  input  logic             wrEn,
  input  logic [WIDTH-1:0] wrAddr,
  input  logic [WIDTH-1:0] wrData,
  output logic             stall,
  output logic             idle,
  output logic [WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0] memWData,
  output logic             memWe,
  input  logic [WIDTH-1:0] memRData
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] buf_addr [DEPTH];
  logic [WIDTH-1:0] buf_data [DEPTH];
  logic [PW-1:0]    head, tail;
  logic [PW:0]      count;
  logic             rd_pending;

  logic             hit, full, rd_acc, wr_acc, drain;
  logic [PW-1:0]    offset;

  // An entry is live when its distance from head is below the occupancy count.
  always_comb begin
    hit    = 1'b0;
    offset = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      offset = PW'(i) - head;
      if (({1'b0, offset} < count) && (buf_addr[i] == rdAddr))
        hit = 1'b1;
    end
    hit = hit & rdEn;
  end

  assign full   = (count == (PW+1)'(DEPTH));
  assign stall  = hit | (full & wrEn);
  assign rd_acc = ~rst & rdEn & ~stall;
  assign wr_acc = ~rst & wrEn & ~stall;
  assign drain  = ~rst & ~rd_acc & (count != '0);

  always_comb begin
    memAddr  = '0;
    memWData = '0;
    memWe    = 1'b0;
    if (rd_acc) begin
      memAddr = rdAddr;
    end else if (drain) begin
      memAddr  = buf_addr[head];
      memWData = buf_data[head];
      memWe    = 1'b1;
    end
  end

  assign rdData  = memRData;
  assign rdValid = rd_pending & ~rst;
  assign idle    = rst | ((count == '0) & ~rd_pending);

  always_ff @(posedge clk) begin
    if (rst) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      rd_pending <= 1'b0;
    end else begin
      rd_pending <= rd_acc;
      if (wr_acc)
        tail <= tail + 1'b1;
      if (drain)
        head <= head + 1'b1;
      case ({wr_acc, drain})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      buf_addr[tail] <= wrAddr;
      buf_data[tail] <= wrData;
    end
  end

endmodule

// File: tb/tb_vertex_mem_responder.sv
// Bench for vertex_mem_responder: behavioural SRAM, queued expectations for read
// responses and SRAM writes, plus directed checks of stall/idle.
module tb_vertex_mem_responder;

  logic        clk = 1'b0;
  logic        rst, rdEn, wrEn, rdValid, stall, idle, memWe;
  logic [31:0] rdAddr, rdData, wrAddr, wrData, memAddr, memWData, memRData;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q [$];
  logic [63:0] wr_q [$];
  logic [31:0] mem [256];

  always #5 clk = ~clk;

  vertex_mem_responder #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .rdEn(rdEn), .rdAddr(rdAddr), .rdData(rdData), .rdValid(rdValid),
    .wrEn(wrEn), .wrAddr(wrAddr), .wrData(wrData),
    .stall(stall), .idle(idle),
    .memAddr(memAddr), .memWData(memWData), .memWe(memWe), .memRData(memRData)
  );

  // SRAM with one-cycle read latency; reset reloads the known contents.
  always @(posedge clk) begin
    memRData <= mem[memAddr[7:0]];
    if (rst) begin
      mem[8'h10] <= 32'h0000CAFE;
      mem[8'h40] <= 32'h00000001;
      mem[8'h80] <= 32'h00008080;
    end else if (memWe) begin
      mem[memAddr[7:0]] <= memWData;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every presented response / SRAM write is matched against the queues.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdValid) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected: got data %h with no read outstanding", rdData);
        end else begin
          chk("rd_data", rdData, rd_q.pop_front());
        end
      end
      if (memWe) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got write %h<=%h with none expected", memAddr, memWData);
        end else begin
          logic [63:0] e;
          e = wr_q.pop_front();
          chk("wr_addr", memAddr, e[63:32]);
          chk("wr_data", memWData, e[31:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; rdEn = 1'b0; wrEn = 1'b0;
    rdAddr = '0; wrAddr = '0; wrData = '0;
    tick(); tick();
    sample();
    chk("rst_rdValid", {31'b0, rdValid}, 32'd0);
    chk("rst_memWe", {31'b0, memWe}, 32'd0);
    chk("rst_stall", {31'b0, stall}, 32'd0);
    chk("rst_idle", {31'b0, idle}, 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // Plain read
    rdEn = 1'b1; rdAddr = 32'h10;
    sample();
    chk("read_memAddr", memAddr, 32'h10);
    chk("read_memWe", {31'b0, memWe}, 32'd0);
    chk("read_stall", {31'b0, stall}, 32'd0);
    rd_q.push_back(32'h0000CAFE);
    tick(); rdEn = 1'b0;
    tick(); tick();

    // Buffered write, drained the following cycle
    wrEn = 1'b1; wrAddr = 32'h20; wrData = 32'h55;
    sample();
    chk("wr_accept_memWe", {31'b0, memWe}, 32'd0);
    chk("wr_accept_stall", {31'b0, stall}, 32'd0);
    wr_q.push_back({32'h20, 32'h55});
    tick(); wrEn = 1'b0;
    tick();
    sample();
    chk("wr_idle_after", {31'b0, idle}, 32'd1);
    tick();

    // Fill buffer behind a stream of reads, fifth write stalls
    rdEn = 1'b1; rdAddr = 32'h80;
    for (int k = 0; k < 4; k++) begin
      wrEn = 1'b1; wrAddr = 32'h50 + k; wrData = 32'h100 + k;
      sample();
      chk("fill_stall", {31'b0, stall}, 32'd0);
      rd_q.push_back(32'h00008080);
      wr_q.push_back({32'h50 + k, 32'h100 + k});
      tick();
    end
    wrAddr = 32'h54; wrData = 32'h104;
    sample();
    chk("full_stall", {31'b0, stall}, 32'd1);
    chk("full_drain_we", {31'b0, memWe}, 32'd1);
    tick(); rdEn = 1'b0;
    sample();
    chk("full_release", {31'b0, stall}, 32'd0);
    wr_q.push_back({32'h54, 32'h104});
    tick(); wrEn = 1'b0;
    repeat (6) tick();
    sample();
    chk("full_idle", {31'b0, idle}, 32'd1);
    tick();

    // Read hazard on a buffered address
    wrEn = 1'b1; wrAddr = 32'h30; wrData = 32'h77;
    sample();
    chk("haz_wr_stall", {31'b0, stall}, 32'd0);
    wr_q.push_back({32'h30, 32'h77});
    tick(); wrEn = 1'b0; rdEn = 1'b1; rdAddr = 32'h30;
    sample();
    chk("haz_stall", {31'b0, stall}, 32'd1);
    tick();
    sample();
    chk("haz_release", {31'b0, stall}, 32'd0);
    rd_q.push_back(32'h77);
    tick(); rdEn = 1'b0;
    tick(); tick();

    // Same-cycle read and write to one address: read sees old value
    rdEn = 1'b1; wrEn = 1'b1; rdAddr = 32'h40; wrAddr = 32'h40; wrData = 32'h2;
    sample();
    chk("same_stall", {31'b0, stall}, 32'd0);
    rd_q.push_back(32'h1);
    wr_q.push_back({32'h40, 32'h2});
    tick(); rdEn = 1'b0; wrEn = 1'b0;
    repeat (3) tick();
    rdEn = 1'b1; rdAddr = 32'h40;
    sample();
    chk("same_reread_stall", {31'b0, stall}, 32'd0);
    rd_q.push_back(32'h2);
    tick(); rdEn = 1'b0;
    tick(); tick();

    // Reset with writes still buffered: nothing more reaches SRAM
    rdEn = 1'b1; rdAddr = 32'h80;
    for (int k = 0; k < 3; k++) begin
      wrEn = 1'b1; wrAddr = 32'h60 + k; wrData = 32'h200 + k;
      sample();
      chk("rstbuf_stall", {31'b0, stall}, 32'd0);
      if (k < 2) rd_q.push_back(32'h00008080);
      tick();
    end
    rdEn = 1'b0; wrEn = 1'b0; rst = 1'b1;
    sample();
    chk("rstmid_memWe", {31'b0, memWe}, 32'd0);
    chk("rstmid_idle", {31'b0, idle}, 32'd1);
    chk("rstmid_rdValid", {31'b0, rdValid}, 32'd0);
    tick(); rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("post_rst_memWe", {31'b0, memWe}, 32'd0);
      chk("post_rst_idle", {31'b0, idle}, 32'd1);
      tick();
    end

    chk("rd_queue_empty", rd_q.size(), 32'd0);
    chk("wr_queue_empty", wr_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
